// File: rtl/layer_mean_ctrl.sv
// layer_mean_ctrl: mean of one SIZE x SIZE tile of signed fixed-point elements.
// Elements stream in through a valid/ready handshake and are summed into a
// double-width accumulator. The sum is floor-divided by TILE with an
// arithmetic shift, and the result is held until the consumer takes it.
module layer_mean_ctrl #(
   parameter int IL   = 4,
   parameter int FL   = 16,
   parameter int SIZE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IL+FL-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IL+FL-1:0] out_mean,
   output logic             busy
);

   localparam int W    = IL + FL;
   localparam int AW   = 2 * W;
   localparam int TILE = SIZE * SIZE;
   localparam int SH   = $clog2(TILE);
   localparam int CW   = SH + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DIV   = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t                state, state_nx;
   logic signed [AW-1:0]  acc;
   logic [CW-1:0]         cnt;
   logic [W-1:0]          mean_q;
   logic signed [AW-1:0]  elem_ext;
   logic                  accept;
   logic                  last_accept;

   // The element is widened with its sign bit so negative values sum correctly.
   assign elem_ext    = {{W{in_data[W-1]}}, in_data};
   assign accept      = (state == ACCUM) && in_valid;
   assign last_accept = accept && (cnt == CW'(TILE - 1));

   // Handshake and status outputs are pure decodes of the state register.
   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == OUT);
   assign busy      = (state != IDLE);
   assign out_mean  = mean_q;

   // State register plus datapath: accumulate, count and latch the mean.
   always_ff @(posedge clk) begin
      // NOTE: every register here, including the accumulator, is cleared by the
      // synchronous reset so an aborted tile leaves nothing behind.
      if (!rst_n) begin
         state  <= IDLE;
         acc    <= '0;
         cnt    <= '0;
         mean_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register reading the
         // pre-edge value of its neighbours, independent of statement order.
         state <= state_nx;
         case (state)
            IDLE: begin
               if (start) begin
                  acc <= '0;
                  cnt <= '0;
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc <= acc + elem_ext;
                  cnt <= cnt + CW'(1);
               end
            end
            DIV: begin
               // Arithmetic shift by log2(TILE) floors toward -inf; the
               // selected window is exactly the low W bits of acc >>> SH.
               mean_q <= acc[SH +: W];
            end
            default: begin
               mean_q <= mean_q;
            end
         endcase
      end
   end

   // Next-state logic; out_ready and start only matter in their own states.
   always_comb begin
      // NOTE: the default assignment first means no path leaves state_nx
      // unassigned, so no latch can be inferred.
      state_nx = state;
      case (state)
         IDLE:    if (start)       state_nx = ACCUM;
         ACCUM:   if (last_accept) state_nx = DIV;
         DIV:                      state_nx = OUT;
         OUT:     if (out_ready)   state_nx = IDLE;
         default:                  state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_layer_mean_ctrl.sv
// Self-checking bench for layer_mean_ctrl (IL=4, FL=16, SIZE=4, TILE=16).
// Inputs are driven 1 ns after the rising edge; outputs are read at that
// same point, well away from the next active edge.
module tb_layer_mean_ctrl;

   localparam int W    = 20;
   localparam int TILE = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_mean;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] cur [TILE];

   typedef struct {
      logic [W-1:0] a;
      int           n_a;
      logic [W-1:0] b;
      int           gap;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs [11];

   layer_mean_ctrl #(.IL(4), .FL(16), .SIZE(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mean  (out_mean),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: sum the signed elements, floor-divide by TILE, wrap to W bits.
   function automatic logic [W-1:0] ref_mean();
      longint sum = 0;
      longint q;
      for (int i = 0; i < TILE; i++) begin
         longint v = longint'(cur[i]);
         if (v >= 524288) v = v - 1048576;
         sum += v;
      end
      q = sum / TILE;
      if ((sum % TILE) != 0 && sum < 0) q = q - 1;
      return W'(q);
   endfunction

   // One complete tile: start (with a stray element that must be refused),
   // feed cur[] with random gaps, check latency, hold OUT for bp cycles.
   task automatic run_tile(input logic [W-1:0] exp, input int gap_pct, input int bp,
                           input bit finish_out);
      int  n_acc = 0;
      int  guard = 0;
      bit  acc;
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 20'h7FFFF;
      out_ready = 1'b0;
      step();
      start    = 1'b0;
      in_valid = 1'b0;
      check("busy after start", busy, 1);
      check("in_ready in accum", in_ready, 1);
      while (n_acc < TILE && guard < 400) begin
         in_valid  = ($urandom_range(0, 99) >= gap_pct);
         in_data   = in_valid ? cur[n_acc] : W'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         start     = 1'($urandom_range(0, 1));
         acc       = in_valid && in_ready;
         step();
         if (acc) n_acc++;
         guard++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      start     = 1'b0;
      check("accept count", n_acc, TILE);
      check("in_ready after last accept", in_ready, 0);
      check("out_valid at t+1", out_valid, 0);
      step();
      check("out_valid at t+2", out_valid, 1);
      check("out_mean", out_mean, exp);
      for (int i = 0; i < bp; i++) begin
         out_ready = 1'b0;
         start     = 1'($urandom_range(0, 1));
         step();
         check("out_valid held", out_valid, 1);
         check("out_mean held", out_mean, exp);
      end
      start = 1'b0;
      if (finish_out) begin
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         check("busy after take", busy, 0);
         check("out_valid after take", out_valid, 0);
      end
   endtask

   task automatic fill(input logic [W-1:0] a, input int n_a, input logic [W-1:0] b);
      for (int i = 0; i < TILE; i++) cur[i] = (i < n_a) ? a : b;
   endtask

   initial begin
      vecs[0]  = '{20'h10000, 16, 20'h00000, 0,  20'h10000};
      vecs[1]  = '{20'h20000, 8,  20'hF0000, 40, 20'h08000};
      vecs[2]  = '{20'hFFFFF, 1,  20'h00000, 30, 20'hFFFFF};
      vecs[3]  = '{20'h30000, 16, 20'h00000, 20, 20'h30000};
      vecs[4]  = '{20'h80000, 16, 20'h00000, 20, 20'h80000};
      vecs[5]  = '{20'h7FFFF, 16, 20'h00000, 20, 20'h7FFFF};
      vecs[6]  = '{20'h00001, 15, 20'h00000, 20, 20'h00000};
      vecs[7]  = '{20'h00001, 16, 20'h00000, 20, 20'h00001};
      vecs[8]  = '{20'hFFFFF, 16, 20'h00000, 20, 20'hFFFFF};
      vecs[9]  = '{20'hFFFF0, 1,  20'h00000, 20, 20'hFFFFF};
      vecs[10] = '{20'hFFFEF, 1,  20'h00000, 20, 20'hFFFFE};

      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      step();
      step();
      check("reset in_ready", in_ready, 0);
      check("reset out_valid", out_valid, 0);
      check("reset busy", busy, 0);
      check("reset out_mean", out_mean, 0);
      rst_n = 1'b1;
      step();
      check("idle without start", busy, 0);

      // Table-driven tiles with constant expected means.
      for (int v = 0; v < 11; v++) begin
         fill(vecs[v].a, vecs[v].n_a, vecs[v].b);
         run_tile(vecs[v].exp, vecs[v].gap, 0, 1'b1);
      end

      // Output backpressure with start pulses during OUT; start is not queued.
      fill(20'h20000, 16, 20'h0);
      run_tile(20'h20000, 20, 5, 1'b1);
      step();
      check("start during OUT not queued", busy, 0);

      // Reset after 7 accepts aborts the tile.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_data  = 20'h50000;
         step();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      step();
      check("mid-accum reset in_ready", in_ready, 0);
      check("mid-accum reset out_valid", out_valid, 0);
      check("mid-accum reset busy", busy, 0);
      check("mid-accum reset out_mean", out_mean, 0);
      rst_n = 1'b1;
      step();
      step();
      check("waits for fresh start", busy, 0);
      fill(20'h10000, 16, 20'h0);
      run_tile(20'h10000, 0, 0, 1'b1);

      // Reset while the result is waiting in OUT discards it.
      fill(20'h30000, 16, 20'h0);
      run_tile(20'h30000, 0, 2, 1'b0);
      rst_n = 1'b0;
      step();
      check("out reset out_valid", out_valid, 0);
      check("out reset out_mean", out_mean, 0);
      check("out reset busy", busy, 0);
      rst_n = 1'b1;
      step();

      // Back-to-back tiles: start is raised in the single IDLE cycle.
      fill(20'h10000, 16, 20'h0);
      run_tile(20'h10000, 0, 0, 1'b1);
      fill(20'h30000, 16, 20'h0);
      run_tile(20'h30000, 0, 0, 1'b1);

      // Random tiles against the arithmetic reference.
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < TILE; i++) begin
            if (t % 2 == 0) cur[i] = W'($urandom);
            else            cur[i] = W'($urandom_range(0, 63)) - W'(32);
         end
         run_tile(ref_mean(), 25, int'($urandom_range(0, 3)), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/layer_mean_ctrl.md
LAYER_MEAN_CTRL -- requirements
Module: layer_mean_ctrl

Interface
REQ-001 Parameter IL, default 4, integer bits of the signed fixed-point element.
REQ-002 Parameter FL, default 16, fractional bits of the element.
REQ-003 Parameter SIZE, default 4, tile edge; power of two, at least 2; TILE = SIZE*SIZE elements per tile.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request to begin one tile mean; sampled only in IDLE.
REQ-007 in_valid  input  1  in_data carries a valid element.
REQ-008 in_ready  output  1  block accepts an element this cycle.
REQ-009 in_data  input  IL+FL  signed element, two's complement, FL fractional bits.
REQ-010 out_valid  output  1  out_mean holds the result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out_mean  output  IL+FL  signed mean, same format as in_data.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, ACCUM, DIV and OUT.
REQ-015 IDLE: in_ready=0, out_valid=0; start=1 -> ACCUM, accumulator cleared to 0, element counter cleared to 0.
REQ-016 ACCUM: in_ready=1; an element is accepted on every cycle with in_valid=1, adding sign-extended in_data to the accumulator and incrementing the counter.
REQ-017 Gaps in in_valid SHALL stall the count and leave the accumulator unchanged.
REQ-018 On the acceptance that brings the counter to TILE, next state SHALL be DIV; in_ready SHALL be 0 from the following cycle.
REQ-019 The accumulator width SHALL be 2*(IL+FL) bits, signed; overflow is impossible for the legal SIZE range, so no saturation logic is used.
REQ-020 DIV: out_mean SHALL be registered as accumulator arithmetically shifted right by log2(TILE); this rounds toward negative infinity, with no rounding term added. The low IL+FL bits SHALL be taken, and state SHALL go to OUT.
REQ-021 OUT: out_valid=1 and out_mean SHALL be held stable until out_ready=1; on that cycle state SHALL go to IDLE.
REQ-022 Latency: if the last element is accepted in cycle t, out_valid SHALL first be high in cycle t+2.
REQ-023 start while busy=1 SHALL be ignored; it is not queued.
REQ-024 start and in_valid high in the same IDLE cycle: the element SHALL NOT be accepted, because in_ready=0 in IDLE.
REQ-025 out_ready in any state other than OUT SHALL have no effect.
REQ-026 After the OUT->IDLE transition, a new start SHALL be honoured in the next cycle, giving back-to-back tiles with one IDLE cycle between them.
REQ-027 The counter SHALL be log2(TILE)+1 bits wide and SHALL never exceed TILE.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force state IDLE and clear the accumulator, counter and out_mean to 0; in_ready, out_valid and busy SHALL then be 0.
REQ-029 Reset asserted mid-ACCUM, DIV or OUT SHALL abort the tile with no result delivered; after release the block SHALL wait for a fresh start.
REQ-030 Outputs SHALL be driven from registers or from the state register only; there SHALL be no combinational path from input to output except in_ready, which depends on state only.

Verification (SIZE=4, IL=4, FL=16, TILE=16)
REQ-031 Uniform tile: start, then 16 elements of 0x10000 (1.0) with in_valid held high -> out_valid 2 cycles after the 16th accept, out_mean=0x10000.
REQ-032 Mixed signs: 8 elements of 0x20000 (+2.0) and 8 elements of 0xF0000 (-1.0), with random in_valid gaps -> out_mean=0x08000 (0.5); in_ready falls exactly after the 16th accept.
REQ-033 Floor rounding: one element of 0xFFFFF (-1 LSB) and 15 zeros -> out_mean=0xFFFFF.
REQ-034 Output backpressure: out_ready held 0 for 5 cycles in OUT -> out_valid stays 1 and out_mean stays stable; start pulses during OUT are ignored; one cycle after out_ready=1, busy=0.
REQ-035 Reset mid-tile: rst_n=0 after 7 accepts -> next cycle IDLE with all outputs 0; a new start plus 16 elements of 0x10000 -> out_mean=0x10000, with no contamination from the aborted tile.
REQ-036 Back-to-back: two tiles of 0x10000 and then 0x30000 -> results 0x10000 then 0x30000, separated by exactly one IDLE cycle when start is asserted immediately.
